th_bram_rd_sched: RTL and testbench

//  Read-port scheduler for the threshold line BRAM (LINE_W bits/row, 2 b/pixel, ROW_SIZE rows).

---
 rtl/th_bram_rd_sched.sv | 92 +++++++++
 tb/tb_th_bram_rd_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/th_bram_rd_sched.sv
// Read-port scheduler for the threshold line BRAM: arbitrates two row requesters onto one
// read port, blocks reads of rows not yet committed this frame, and returns tagged responses.
module th_bram_rd_sched #(
  parameter int ROW_SIZE = 360,
  parameter int LINE_W   = 1280,
  parameter int ADDR_W   = 9,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic              i_row_wr_done,
  output logic [ADDR_W:0]   o_rows_avail,
  input  logic [1:0]        i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  output logic [1:0]        o_req_ready,
  output logic              o_enb,
  output logic [ADDR_W-1:0] o_addrb,
  input  logic [LINE_W-1:0] i_doutb,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic              o_rsp_err,
  output logic [LINE_W-1:0] o_rsp_data
);

  localparam logic [ADDR_W:0] ROW_CNT = (ADDR_W+1)'(ROW_SIZE);

  logic              last_grant;   // requester granted most recently; the other wins a tie
  logic              in_range0, in_range1;
  logic              elig0, elig1;
  logic              handshake;
  logic              sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_in_range;
  logic [RD_LAT:0]   pipe_valid;
  logic [RD_LAT:0]   pipe_id;
  logic [RD_LAT:0]   pipe_err;

  // NOTE: every signal in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    in_range0   = {1'b0, i_req_addr0} < ROW_CNT;
    in_range1   = {1'b0, i_req_addr1} < ROW_CNT;
    elig0       = i_req_valid[0] && (!in_range0 || ({1'b0, i_req_addr0} < o_rows_avail));
    elig1       = i_req_valid[1] && (!in_range1 || ({1'b0, i_req_addr1} < o_rows_avail));
    o_req_ready = 2'b00;
    if (!rst) begin
      if (elig0 && elig1) o_req_ready = last_grant ? 2'b01 : 2'b10;
      else if (elig0)     o_req_ready = 2'b01;
      else if (elig1)     o_req_ready = 2'b10;
    end
    handshake    = |o_req_ready;
    sel_id       = o_req_ready[1];
    sel_addr     = sel_id ? i_req_addr1 : i_req_addr0;
    sel_in_range = sel_id ? in_range1 : in_range0;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rows_avail <= '0;
      last_grant   <= 1'b1;
      o_enb        <= 1'b0;
      o_addrb      <= '0;
      pipe_valid   <= '0;
      pipe_id      <= '0;
      pipe_err     <= '0;
    end else begin
      if (i_frame_start)
        o_rows_avail <= '0;
      else if (i_row_wr_done && (o_rows_avail != ROW_CNT))
        o_rows_avail <= o_rows_avail + 1'b1;

      if (handshake) last_grant <= sel_id;

      // Out-of-range requests get an error response but never touch the BRAM.
      o_enb <= handshake && sel_in_range;
      if (handshake && sel_in_range) o_addrb <= sel_addr;

      // Stage 0 aligns with o_enb; stage RD_LAT aligns with i_doutb.
      pipe_valid <= {pipe_valid[RD_LAT-1:0], handshake};
      pipe_id    <= {pipe_id[RD_LAT-1:0], sel_id};
      pipe_err   <= {pipe_err[RD_LAT-1:0], handshake && !sel_in_range};
    end
  end

  assign o_rsp_valid = pipe_valid[RD_LAT];
  assign o_rsp_id    = pipe_id[RD_LAT];
  assign o_rsp_err   = pipe_err[RD_LAT];
  assign o_rsp_data  = o_rsp_err ? '0 : i_doutb;

endmodule

// File: tb/tb_th_bram_rd_sched.sv
// Directed bench for th_bram_rd_sched with a 1-cycle BRAM model whose row r holds a
// recognisable pattern, so returned data can be matched to the requested row.
module tb_th_bram_rd_sched;

  localparam int ROW_SIZE = 360;
  localparam int LINE_W   = 1280;
  localparam int ADDR_W   = 9;
  localparam int RD_LAT   = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start, row_wr_done;
  logic [ADDR_W:0]   rows_avail;
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [1:0]        req_ready;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [LINE_W-1:0] doutb = '0;
  logic              rsp_valid, rsp_id, rsp_err;
  logic [LINE_W-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  th_bram_rd_sched #(.ROW_SIZE(ROW_SIZE), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_frame_start(frame_start), .i_row_wr_done(row_wr_done), .o_rows_avail(rows_avail),
    .i_req_valid(req_valid), .i_req_addr0(req_addr0), .i_req_addr1(req_addr1),
    .o_req_ready(req_ready), .o_enb(enb), .o_addrb(addrb), .i_doutb(doutb),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] row_word(input int r);
    logic [LINE_W-1:0] w;
    w = '0;
    for (int i = 0; i < LINE_W/16; i++) w[i*16 +: 16] = 16'((i << 9) | r);
    return w;
  endfunction

  always @(posedge clk) if (enb) doutb <= row_word(int'(addrb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [LINE_W-1:0] exp);
    checks++;
    assert (rsp_data === exp) else begin
      errors++;
      $error("FAIL %s: observed lo %0h hi %0h expected lo %0h hi %0h", tag,
             rsp_data[63:0], rsp_data[LINE_W-1 -: 64], exp[63:0], exp[LINE_W-1 -: 64]);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; row_wr_done = 1'b0;
    req_valid = 2'b11; req_addr0 = '0; req_addr1 = 9'd360;

    // Reset held with both requesters asking (one of them out of range).
    for (int i = 0; i < 3; i++) begin
      edge_step(); #2;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_enb", 32'(enb), 32'h0);
      check("rst_addrb", 32'(addrb), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'h0);
      check("rst_rows", 32'(rows_avail), 32'h0);
    end
    edge_step(); rst = 1'b0; req_addr0 = 9'd5; req_addr1 = 9'd7; #2;
    check("post_rst_ready", 32'(req_ready), 32'h0);
    edge_step(); #2;
    check("post_rst_ready2", 32'(req_ready), 32'h0);

    // First committed row unlocks row 0.
    edge_step(); req_valid = 2'b01; req_addr0 = 9'd0; row_wr_done = 1'b1; #2;
    check("row0_blocked", 32'(req_ready), 32'h0);
    edge_step(); row_wr_done = 1'b0; #2;
    check("rows_1", 32'(rows_avail), 32'd1);
    check("row0_ready", 32'(req_ready), 32'h1);
    edge_step(); req_valid = 2'b00; #2;
    check("row0_enb", 32'(enb), 32'h1);
    check("row0_addrb", 32'(addrb), 32'h0);
    check("row0_rsp_early", 32'(rsp_valid), 32'h0);
    edge_step(); #2;
    check("row0_rsp_valid", 32'(rsp_valid), 32'h1);
    check("row0_rsp_id", 32'(rsp_id), 32'h0);
    check("row0_rsp_err", 32'(rsp_err), 32'h0);
    check("row0_enb_off", 32'(enb), 32'h0);
    check_data("row0_data", row_word(0));

    // Fresh reset, five rows committed, both requesters contend.
    edge_step(); rst = 1'b1;
    edge_step(); rst = 1'b0; row_wr_done = 1'b1;
    for (int i = 0; i < 5; i++) edge_step();
    row_wr_done = 1'b0; req_valid = 2'b11; req_addr0 = 9'd2; req_addr1 = 9'd4;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) edge_step();
      if (k == 6) req_valid = 2'b00;
      #2;
      if (k == 0) check("rows_5", 32'(rows_avail), 32'd5);
      if (k < 6) check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 1 && k <= 6) begin
        check("rr_enb", 32'(enb), 32'h1);
        check("rr_addrb", 32'(addrb), ((k - 1) % 2 == 0) ? 32'd2 : 32'd4);
      end
      if (k >= 2) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 2));
        check_data("rr_data", row_word(((k - 2) % 2 == 0) ? 2 : 4));
      end
    end
    edge_step(); #2;
    check("rr_drain", 32'(rsp_valid), 32'h0);

    // New frame with three rows: row 3 blocked, row 360 is an error read.
    frame_start = 1'b1;
    edge_step(); frame_start = 1'b0; row_wr_done = 1'b1;
    for (int i = 0; i < 3; i++) edge_step();
    row_wr_done = 1'b0; req_valid = 2'b10; req_addr1 = 9'd3; #2;
    check("rows_3", 32'(rows_avail), 32'd3);
    check("row3_blocked", 32'(req_ready), 32'h0);
    edge_step(); #2;
    check("row3_blocked2", 32'(req_ready), 32'h0);
    req_addr1 = 9'd360; #1;
    check("oor_ready", 32'(req_ready), 32'h2);
    edge_step(); req_valid = 2'b00; #2;
    check("oor_no_enb", 32'(enb), 32'h0);
    check("oor_addrb_hold", 32'(addrb), 32'd4);
    check("oor_rsp_early", 32'(rsp_valid), 32'h0);
    edge_step(); #2;
    check("oor_rsp_valid", 32'(rsp_valid), 32'h1);
    check("oor_rsp_id", 32'(rsp_id), 32'h1);
    check("oor_rsp_err", 32'(rsp_err), 32'h1);
    check_data("oor_data_zero", '0);
    edge_step(); #2;
    check("oor_drain", 32'(rsp_valid), 32'h0);

    // Row count saturates at ROW_SIZE; frame_start beats a simultaneous wr_done.
    row_wr_done = 1'b1;
    for (int i = 0; i < 400; i++) begin
      edge_step();
      if (i == 355) begin
        #2;
        check("rows_359", 32'(rows_avail), 32'd359);
      end
    end
    row_wr_done = 1'b0; #2;
    check("rows_sat", 32'(rows_avail), 32'd360);
    frame_start = 1'b1; row_wr_done = 1'b1;
    edge_step(); frame_start = 1'b0; row_wr_done = 1'b0; #2;
    check("rows_frame_clr", 32'(rows_avail), 32'd0);

    // Reset with reads in flight drops them and restarts the round robin.
    row_wr_done = 1'b1;
    for (int i = 0; i < 4; i++) edge_step();
    row_wr_done = 1'b0; req_valid = 2'b11; req_addr0 = 9'd1; req_addr1 = 9'd2; #2;
    check("fl_ready0", 32'(req_ready), 32'h1);
    edge_step(); #2;
    check("fl_ready1", 32'(req_ready), 32'h2);
    edge_step(); req_valid = 2'b00; rst = 1'b1; #2;
    check("fl_rsp_first", 32'(rsp_valid), 32'h1);
    check("fl_rsp_first_id", 32'(rsp_id), 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      if (i == 1) rst = 1'b0;
      #2;
      check("fl_rsp_dropped", 32'(rsp_valid), 32'h0);
      check("fl_enb_off", 32'(enb), 32'h0);
    end
    check("fl_rows_clr", 32'(rows_avail), 32'd0);
    req_valid = 2'b11; req_addr0 = 9'd360; req_addr1 = 9'd360; #2;
    check("fl_rr_restart", 32'(req_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
